// File: rtl/uart_tx.sv
// uart_tx -- serial UART transmitter.
//
// Accepts a parallel word over a valid/ready handshake and shifts it out on
// a single line. The frame is a start bit (0), DATA_W data bits LSB first,
// an optional even-parity bit, then a stop bit (1). Each bit lasts
// CLKS_PER_BIT clock cycles. The line idles high.
//
// Parameters:
//   DATA_W        data bits per frame (1..16)
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   PARITY_EN     1 inserts an even-parity bit after the data bits
//
// Ports:
//   clk      single clock, rising edge
//   rst      synchronous active-high reset
//   s_data   word to transmit
//   s_valid  s_data is valid
//   s_ready  transmitter can accept a word (registered)
//   tx       serial line output (registered)
//   busy     a frame is in progress (registered)
module uart_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              tx,
    output logic              busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    // DATA_W+1 keeps the width at least 1 when DATA_W is 1.
    localparam int BIT_W  = $clog2(DATA_W + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_nxt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_nxt;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_nxt;
    logic              parity_q;
    logic              parity_nxt;
    logic              tx_nxt;
    logic              take;
    logic              bit_end;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // Next-state, counters and the value tx will carry next cycle.
    always_comb begin
        state_nxt  = state;
        baud_nxt   = baud_cnt;
        bit_nxt    = bit_cnt;
        shift_nxt  = shift_q;
        parity_nxt = parity_q;
        tx_nxt     = 1'b1;
        take       = s_ready && s_valid;
        bit_end    = (baud_cnt == BAUD_LAST);

        case (state)
            IDLE: begin
                if (take) begin
                    state_nxt  = START;
                    baud_nxt   = '0;
                    bit_nxt    = '0;
                    shift_nxt  = s_data;
                    parity_nxt = even_parity(s_data);
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_nxt  = '0;
                    shift_nxt = shift_q >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                        bit_nxt   = '0;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                baud_nxt  = '0;
                bit_nxt   = '0;
            end
        endcase

        // tx is registered, so it is derived from where the FSM is going.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            PARITY:  tx_nxt = parity_nxt;
            default: tx_nxt = 1'b1;
        endcase
    end

    // Control state: reset forces an idle-high line with s_ready low for
    // one cycle, aborting any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            s_ready  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            tx       <= tx_nxt;
            s_ready  <= (state_nxt == IDLE);
            busy     <= (state_nxt != IDLE);
        end
    end

    // Datapath: only loaded on a handshake, so it needs no reset.
    always_ff @(posedge clk) begin
        shift_q  <= shift_nxt;
        parity_q <= parity_nxt;
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- self-checking bench for uart_tx.
//
// Two transmitters (parity off / parity on, 8 data bits, 4 clocks per bit)
// share the same stimulus. A behavioural model records, for each instance,
// the handshake cycle and the accepted word; the expected line level in any
// later cycle follows from the offset to that handshake. Directed sequences
// pin the model with literal frame patterns, then a random phase follows.
module tb_uart_tx;

    localparam int C  = 4;
    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid;
    logic [1:0] tx;
    logic [1:0] rdy_o;
    logic [1:0] busy_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(C), .PARITY_EN(0)) u0 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy_o[0]), .tx(tx[0]), .busy(busy_o[0])
    );

    uart_tx #(.DATA_W(DW), .CLKS_PER_BIT(C), .PARITY_EN(1)) u1 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid),
        .s_ready(rdy_o[1]), .tx(tx[1]), .busy(busy_o[1])
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         cyc = 0;
    bit         act [2];
    int         k   [2];
    logic [7:0] wd  [2];
    bit         rdy [2];
    bit         chk_en = 1'b0;

    function automatic int flen(input int m);
        return DW + 2 + m;
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                act[m] = 1'b0;
                rdy[m] = 1'b0;
            end else if (act[m]) begin
                if (cyc == k[m] + flen(m) * C) begin
                    act[m] = 1'b0;
                    rdy[m] = 1'b1;
                end
            end else if (rdy[m] && s_valid) begin
                act[m] = 1'b1;
                k[m]   = cyc;
                wd[m]  = s_data;
                rdy[m] = 1'b0;
            end else begin
                rdy[m] = 1'b1;
            end
        end
        if (rst) chk_en = 1'b1;
        cyc++;
    end

    function automatic logic exp_tx(input int m);
        int pos;
        int b;
        if (!act[m]) return 1'b1;
        pos = cyc - k[m] - 1;
        b   = pos / C;
        if (b == 0) return 1'b0;
        if (b <= DW) return wd[m][b-1];
        if (m == 1 && b == DW + 1) return ^wd[m];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("model_tx%0d", m), tx[m], exp_tx(m));
                chk($sformatf("model_ready%0d", m), rdy_o[m], rdy[m]);
                chk($sformatf("model_busy%0d", m), busy_o[m], act[m]);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic send(input logic [7:0] d, output int kk);
        int n;
        n = 0;
        while (!(rdy[0] && rdy[1]) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!(rdy[0] && rdy[1])) begin
            checks++;
            errors++;
            $display("FAIL send_wait: ready got 0 expected 1 within 500 cycles");
        end
        s_valid = 1'b1;
        s_data  = d;
        kk      = cyc;
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    // Entered at the negedge of cycle k+1; walks the frame bit by bit
    // against a literal pattern (bit 0 = start bit), then checks s_ready.
    task automatic watch(input int m, input logic [15:0] pat, input int nb, input bit jitter);
        for (int j = 0; j < nb; j++) begin
            for (int r = 0; r < C; r++) begin
                chk($sformatf("pat%0d_bit%0d", m, j), tx[m], pat[j]);
                if (jitter) begin
                    s_valid = 1'($urandom_range(0, 1));
                    s_data  = 8'($urandom);
                end
                @(negedge clk);
            end
        end
        chk($sformatf("ready_after_frame%0d", m), rdy_o[m], 1'b1);
        s_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int kk;
        logic [15:0] pat;

        // Reset held 3 cycles with s_valid high: nothing may start.
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h81;
        repeat (3) begin
            @(negedge clk);
            chk("rst_tx", tx[0], 1'b1);
            chk("rst_ready", rdy_o[0], 1'b0);
            chk("rst_busy", busy_o[1], 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("release_ready0", rdy_o[0], 1'b1);
        chk("release_ready1", rdy_o[1], 1'b1);
        chk("release_tx", tx[0], 1'b1);
        @(negedge clk);
        s_valid = 1'b0;

        // 0xA5 on the parity-less instance; s_ready back at k+41.
        send(8'hA5, kk);
        pat = {6'b0, 1'b1, 8'hA5, 1'b0};
        watch(0, pat, 10, 1'b0);
        chk("k41_cycle", 1'(cyc == kk + 41), 1'b1);

        // Parity: 0x07 -> parity 1, with inputs churning mid-frame.
        send(8'h07, kk);
        pat = {5'b0, 1'b1, 1'b1, 8'h07, 1'b0};
        watch(1, pat, 11, 1'b1);

        // Parity: 0x03 -> parity 0.
        send(8'h03, kk);
        pat = {5'b0, 1'b1, 1'b0, 8'h03, 1'b0};
        watch(1, pat, 11, 1'b0);

        // Back-to-back with s_valid held high: 0x55 then 0xAA.
        while (!(rdy[0] && rdy[1])) @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'h55;
        kk      = cyc;
        @(negedge clk);
        s_data = 8'hAA;
        while (cyc < kk + 40) @(negedge clk);
        chk("b2b_stop", tx[0], 1'b1);
        @(negedge clk);
        chk("b2b_gap_tx", tx[0], 1'b1);
        chk("b2b_gap_ready", rdy_o[0], 1'b1);
        @(negedge clk);
        chk("b2b_second_start", tx[0], 1'b0);
        chk("b2b_second_busy", busy_o[0], 1'b1);
        while (cyc < kk + 46) @(negedge clk);
        s_valid = 1'b0;

        // Reset during data bit 3 (cycles k+17..k+20).
        send(8'h96, kk);
        while (cyc < kk + 18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", tx[0], 1'b1);
        chk("abort_busy", busy_o[0], 1'b0);
        chk("abort_ready", rdy_o[0], 1'b0);
        chk("abort_busy1", busy_o[1], 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_release_ready", rdy_o[0], 1'b1);
        send(8'h3C, kk);
        pat = {6'b0, 1'b1, 8'h3C, 1'b0};
        watch(0, pat, 10, 1'b0);

        // Random phase: valid, data and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
            rst     = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst     = 1'b0;
        s_valid = 1'b0;
        repeat (60) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
